regfile_bypass: RTL
===================

Name: regfile_bypass

Overview:
- Parametrised successor to the core integer register file: configurable data width, depth and number of registered read ports.
- Adds write-to-read bypass, a per-register pending scoreboard for hazard detection, and a hardware clear sequencer that zeroes storage after reset or on request.
- Sits between decode (read addresses, reservations) and writeback (write port), clocked on the APB clock domain.

Parameters:
XLEN, 32, data width in bits
AW, 5, address width; depth = 2**AW entries
NRD, 2, number of read ports
ZERO_REG, 1, 1 = entry 0 reads as 0, is never written and is never pending
BYPASS, 1, 1 = same-cycle write data forwarded to reads of the same address

Ports:
APB_PCLK  input  1  clock, all logic on rising edge
APB_PRESETn  input  1  reset, asynchronous, active-low
clear_req  input  1  pulse: restart clear sweep, drop all pending bits
busy  output  1  high while clear sweep runs
write_reg  input  1  write enable
wa  input  AW  write address
rd0  input  XLEN  write data
rsv_en  input  1  mark register rsv_addr pending
rsv_addr  input  AW  reservation address
read_reg  input  1  read enable, all ports together
ra  input  NRD*AW  read addresses, port i at [i*AW +: AW]
rs  output  NRD*XLEN  registered read data, port i at [i*XLEN +: XLEN]
hazard  output  NRD  registered: port i read a pending register

Behaviour:
- Reset (APB_PRESETn low, async): rs=0, hazard=0, pending bits=0, FSM=CLEAR, sweep index=0, busy=1. Storage array is not reset (RAM-inferable); zeroed by the sweep.
- FSM states IDLE, CLEAR. CLEAR: each cycle write 0 to entry[index], index++. After writing entry 2**AW-1, go to IDLE next cycle; busy=0 in IDLE. Sweep takes exactly 2**AW cycles after reset release.
- clear_req in IDLE: go to CLEAR, index=0, pending all cleared. clear_req in CLEAR: index restarts at 0.
- While busy: write_reg, rsv_en, read_reg ignored; rs and hazard hold.
- Write (IDLE): write_reg=1 stores rd0 at wa at the clock edge and clears pending[wa]. With ZERO_REG=1 and wa=0: no store.
- Read (IDLE): read_reg=1 updates rs/hazard at the clock edge (1-cycle latency); read_reg=0 holds both.
- Read data per port: ZERO_REG and ra_i=0 -> 0; else BYPASS and write_reg and wa==ra_i -> rd0; else stored entry (old value when BYPASS=0).
- hazard_i = pending[ra_i] and not (BYPASS and write_reg and wa==ra_i); always 0 for entry 0 when ZERO_REG.
- Reservation: rsv_en sets pending[rsv_addr]. Same-cycle write and reservation to one address: pending ends set (reservation wins), data stored. rsv_addr=0 ignored when ZERO_REG.
- Read and write in one cycle is legal (no warning); multiple read ports may share an address.

Decomposition:
- Shared package: FSM state encoding (IDLE, CLEAR), default XLEN/AW constants shared with decode and writeback.
- One natural sub-module: regfile_scoreboard (2**AW pending bits, set/clear/flush, NRD lookup ports).

Test Plan:
- Reset release -> busy=1 for exactly 32 cycles (AW=5), then 0; read x1..x31 -> rs=0, hazard=0.
- Write x5=0xDEADBEEF, next cycle read ra0=5 -> rs0=0xDEADBEEF after 1 cycle; read ra1=0 after writing x0=0x1234 -> rs1=0.
- Same cycle write x7=0xA5A5A5A5 and read ra0=7: BYPASS=1 -> rs0=0xA5A5A5A5; BYPASS=0 -> previous x7 value.
- rsv_en x3, read ra0=3 -> hazard[0]=1; write x3=0x11 with read ra0=3 same cycle -> rs0=0x11, hazard[0]=0 (BYPASS=1); next read -> hazard[0]=0.
- clear_req mid-sweep at index 10 -> sweep restarts at 0, busy stays high 32 more cycles; writes during busy dropped (x9 reads 0 afterwards).
- Assert APB_PRESETn low mid-operation with x4 pending and rs0 nonzero -> rs=0, hazard=0, busy=1 immediately without a clock edge.

Source files
------------

// File: rtl/regfile_bypass_pkg.sv
// rtl/regfile_bypass_pkg.sv - shared register-file state encoding and default sizes
package regfile_bypass_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_XLEN_DEFAULT = 32;
  localparam int RF_AW_DEFAULT   = 5;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits with set/clear/flush and lookup ports
module regfile_scoreboard
  import regfile_bypass_pkg::*;
#(
  parameter int AW       = RF_AW_DEFAULT,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            set_en_i,
  input  logic [AW-1:0]   set_addr_i,
  input  logic            clr_en_i,
  input  logic [AW-1:0]   clr_addr_i,
  input  logic [NRD*AW-1:0] lookup_addr_i,
  output logic [NRD-1:0]  lookup_pend_o
);

  localparam int DEPTH = 2 ** AW;

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // Set is applied after clear so a same-cycle reservation outlives the write.
  always_comb begin
    pending_d = pending_q;
    if (flush_i) begin
      pending_d = '0;
    end else begin
      if (clr_en_i) pending_d[clr_addr_i] = 1'b0;
      if (set_en_i) pending_d[set_addr_i] = 1'b1;
    end
    if (ZERO_REG != 0) pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  always_comb begin
    lookup_pend_o = '0;
    for (int i = 0; i < NRD; i++) begin
      lookup_pend_o[i] = pending_q[lookup_addr_i[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - parametrised register file with write bypass, pending scoreboard and clear sweep
module regfile_bypass
  import regfile_bypass_pkg::*;
#(
  parameter int XLEN     = RF_XLEN_DEFAULT,
  parameter int AW       = RF_AW_DEFAULT,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              APB_PCLK,
  input  logic              APB_PRESETn,
  input  logic              clear_req,
  output logic              busy,
  input  logic              write_reg,
  input  logic [AW-1:0]     wa,
  input  logic [XLEN-1:0]   rd0,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              read_reg,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*XLEN-1:0] rs,
  output logic [NRD-1:0]    hazard
);

  localparam int DEPTH = 2 ** AW;

  rf_state_e       state_q;
  logic [AW-1:0]   idx_q;
  logic            busy_q;
  logic [XLEN-1:0] mem [DEPTH];

  logic            idle;
  logic            wr_store;
  logic [NRD-1:0]  pend;
  logic [NRD*XLEN-1:0] rs_q, rs_d;
  logic [NRD-1:0]  hazard_q, hazard_d;

  assign idle     = (state_q == ST_IDLE);
  assign wr_store = idle && write_reg && !((ZERO_REG != 0) && (wa == '0));

  always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
    if (!APB_PRESETn) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clear_req) begin
            idx_q <= '0;
          end else if (&idx_q) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset so it can map onto RAM; the sweep zeroes it instead.
  always_ff @(posedge APB_PCLK) begin
    if (state_q == ST_CLEAR) mem[idx_q] <= '0;
    else if (wr_store)       mem[wa]    <= rd0;
  end

  regfile_scoreboard #(
    .AW       (AW),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i         (APB_PCLK),
    .rst_ni        (APB_PRESETn),
    .flush_i       (clear_req),
    .set_en_i      (idle && rsv_en),
    .set_addr_i    (rsv_addr),
    .clr_en_i      (idle && write_reg),
    .clr_addr_i    (wa),
    .lookup_addr_i (ra),
    .lookup_pend_o (pend)
  );

  always_comb begin
    rs_d     = rs_q;
    hazard_d = hazard_q;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      logic          fwd;
      a   = ra[i*AW +: AW];
      fwd = (BYPASS != 0) && write_reg && (wa == a);
      if ((ZERO_REG != 0) && (a == '0)) begin
        rs_d[i*XLEN +: XLEN] = '0;
        hazard_d[i]          = 1'b0;
      end else begin
        rs_d[i*XLEN +: XLEN] = fwd ? rd0 : mem[a];
        hazard_d[i]          = pend[i] && !fwd;
      end
    end
  end

  always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
    if (!APB_PRESETn) begin
      rs_q     <= '0;
      hazard_q <= '0;
    end else if (idle && read_reg) begin
      rs_q     <= rs_d;
      hazard_q <= hazard_d;
    end
  end

  assign rs     = rs_q;
  assign hazard = hazard_q;
  assign busy   = busy_q;

endmodule
